// File: rtl/writeback_lanes_if.sv
// M->W stage bundle between the memory stage, the writeback stage and the
// register file / hazard unit.
interface writeback_lanes_if #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 32
);
  // Hazard-unit control
  logic                          StallW;
  logic                          FlushW;
  // Memory-stage values
  logic [LANES-1:0]              ValidM;
  logic [LANES-1:0][31:0]        PCM;
  logic [LANES-1:0][DATA_W-1:0]  ALUOutM;
  logic [LANES-1:0][REG_W-1:0]   WriteRegM;
  logic [LANES-1:0]              RegWriteM;
  logic [LANES-1:0]              MemtoRegM;
  logic [1:0]                    MemSizeM;
  logic                          MemUnsignedM;
  // Data-bus response
  logic                          dresp_data_ok;
  logic [DATA_W-1:0]             dresp_data;
  // Writeback results
  logic [LANES-1:0][31:0]        PCW;
  logic [LANES-1:0][DATA_W-1:0]  ResultW;
  logic [LANES-1:0][REG_W-1:0]   WriteRegW;
  logic [LANES-1:0]              RegWriteW;
  logic                          StallReqW;
  logic [CNT_W-1:0]              RetiredW;

  modport master (
    output StallW, FlushW, ValidM, PCM, ALUOutM, WriteRegM, RegWriteM, MemtoRegM,
           MemSizeM, MemUnsignedM, dresp_data_ok, dresp_data,
    input  PCW, ResultW, WriteRegW, RegWriteW, StallReqW, RetiredW
  );

  modport slave (
    input  StallW, FlushW, ValidM, PCM, ALUOutM, WriteRegM, RegWriteM, MemtoRegM,
           MemSizeM, MemUnsignedM, dresp_data_ok, dresp_data,
    output PCW, ResultW, WriteRegW, RegWriteW, StallReqW, RetiredW
  );
endinterface

// File: rtl/writeback_lanes.sv
// Multi-lane writeback stage: M->W register, lane-0 load-response buffer with
// late-response wait, sub-word extraction, qualified register-file writes and
// a retired-instruction counter.
module writeback_lanes #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 32
) (
  input logic              clk,
  input logic              reset,
  writeback_lanes_if.slave wb
);
  localparam int NumLanes = int'(LANES);

  typedef enum logic [1:0] {StIdle, StWait, StReady} state_e;

  state_e                       state_q, state_d;
  logic [LANES-1:0]             valid_q, valid_d;
  logic [LANES-1:0][31:0]       pc_q, pc_d;
  logic [LANES-1:0][DATA_W-1:0] alu_q, alu_d;
  logic [LANES-1:0][REG_W-1:0]  wreg_q, wreg_d;
  logic [LANES-1:0]             rw_q, rw_d;
  logic [LANES-1:0]             m2r_q, m2r_d;
  logic [1:0]                   size_q, size_d;
  logic                         uns_q, uns_d;
  logic [DATA_W-1:0]            buf_q, buf_d;
  logic [CNT_W-1:0]             ret_q, ret_d;

  logic                         stall_req;
  logic                         advance;
  logic                         capture;
  logic [1:0]                   off;
  logic [7:0]                   ld_byte;
  logic [15:0]                  ld_half;
  logic [DATA_W-1:0]            load_data;
  logic [LANES-1:0][DATA_W-1:0] result;
  logic [LANES-1:0]             we_base;
  logic [LANES-1:0]             we;

  assign stall_req = (state_q == StWait);
  assign advance   = !(wb.StallW | stall_req);
  // A load enters W this cycle
  assign capture   = advance & !wb.FlushW & wb.ValidM[0] & wb.MemtoRegM[0];

  // W register next state: flush clears valids, stall holds, else load from M
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    alu_d   = alu_q;
    wreg_d  = wreg_q;
    rw_d    = rw_q;
    m2r_d   = m2r_q;
    size_d  = size_q;
    uns_d   = uns_q;
    if (wb.FlushW) begin
      valid_d = '0;
    end else if (advance) begin
      valid_d = wb.ValidM;
      pc_d    = wb.PCM;
      alu_d   = wb.ALUOutM;
      wreg_d  = wb.WriteRegM;
      rw_d    = wb.RegWriteM;
      m2r_d   = wb.MemtoRegM;
      size_d  = wb.MemSizeM;
      uns_d   = wb.MemUnsignedM;
    end
  end

  // Load FSM next state and response buffer capture
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    unique case (state_q)
      StIdle, StReady: begin
        if (wb.FlushW) begin
          state_d = StIdle;
        end else if (advance) begin
          if (capture) begin
            if (wb.dresp_data_ok) begin
              state_d = StReady;
              buf_d   = wb.dresp_data;
            end else begin
              state_d = StWait;
            end
          end else begin
            state_d = StIdle;
          end
        end
      end
      StWait: begin
        if (wb.FlushW) begin
          state_d = StIdle;
        end else if (wb.dresp_data_ok) begin
          state_d = StReady;
          buf_d   = wb.dresp_data;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Retired counter: valid lanes leaving W on an unflushed advance
  always_comb begin
    ret_d = ret_q;
    if (advance && !wb.FlushW) begin
      for (int i = 0; i < NumLanes; i++) begin
        ret_d = ret_d + CNT_W'(valid_q[i]);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      valid_q <= '0;
      pc_q    <= '0;
      alu_q   <= '0;
      wreg_q  <= '0;
      rw_q    <= '0;
      m2r_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      buf_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      wreg_q  <= wreg_d;
      rw_q    <= rw_d;
      m2r_q   <= m2r_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      buf_q   <= buf_d;
      ret_q   <= ret_d;
    end
  end

  // Sub-word extraction of the buffered load word (half ignores address bit 0)
  always_comb begin
    off     = alu_q[0][1:0];
    ld_byte = buf_q[{off, 3'b000} +: 8];
    ld_half = buf_q[{off[1], 4'b0000} +: 16];
    case (size_q)
      2'd0: load_data = uns_q ? {{(DATA_W-8){1'b0}}, ld_byte}
                              : {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      2'd1: load_data = uns_q ? {{(DATA_W-16){1'b0}}, ld_half}
                              : {{(DATA_W-16){ld_half[15]}}, ld_half};
      default: load_data = buf_q;
    endcase
  end

  // Write data and qualified write enables; a higher lane wins a WAW conflict
  always_comb begin
    result = alu_q;
    if (m2r_q[0]) result[0] = load_data;
    for (int i = 0; i < NumLanes; i++) begin
      we_base[i] = valid_q[i] & rw_q[i] & (wreg_q[i] != '0);
    end
    if (state_q == StWait) we_base[0] = 1'b0;
    we = we_base;
    for (int i = 0; i < NumLanes; i++) begin
      for (int j = i + 1; j < NumLanes; j++) begin
        if (we_base[j] && (wreg_q[j] == wreg_q[i])) we[i] = 1'b0;
      end
    end
  end

  assign wb.PCW       = pc_q;
  assign wb.ResultW   = result;
  assign wb.WriteRegW = wreg_q;
  assign wb.RegWriteW = we;
  assign wb.StallReqW = stall_req;
  assign wb.RetiredW  = ret_q;
endmodule

// File: tb/tb_writeback_lanes.sv
// Directed plus randomized checks of writeback_lanes against a transaction-level
// model; a second instance with a 4-bit counter shares the stimulus.
module tb_writeback_lanes;
  localparam int L = 2;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  writeback_lanes_if #(.LANES(L), .DATA_W(32), .REG_W(5), .CNT_W(32)) if0 ();
  writeback_lanes_if #(.LANES(L), .DATA_W(32), .REG_W(5), .CNT_W(4))  if1 ();

  writeback_lanes #(.LANES(L), .DATA_W(32), .REG_W(5), .CNT_W(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .wb    (if0)
  );

  writeback_lanes #(.LANES(L), .DATA_W(32), .REG_W(5), .CNT_W(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .wb    (if1)
  );

  assign if1.StallW        = if0.StallW;
  assign if1.FlushW        = if0.FlushW;
  assign if1.ValidM        = if0.ValidM;
  assign if1.PCM           = if0.PCM;
  assign if1.ALUOutM       = if0.ALUOutM;
  assign if1.WriteRegM     = if0.WriteRegM;
  assign if1.RegWriteM     = if0.RegWriteM;
  assign if1.MemtoRegM     = if0.MemtoRegM;
  assign if1.MemSizeM      = if0.MemSizeM;
  assign if1.MemUnsignedM  = if0.MemUnsignedM;
  assign if1.dresp_data_ok = if0.dresp_data_ok;
  assign if1.dresp_data    = if0.dresp_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: instructions currently in W, whether lane 0's load has its data yet
  logic [L-1:0]        mv, mrw, mm2r;
  logic [L-1:0][31:0]  mpc, malu;
  logic [L-1:0][4:0]   mwr;
  logic [1:0]          msz;
  logic                mun;
  logic                mhave;
  logic [31:0]         mdata;
  logic [31:0]         mret;

  function automatic logic model_waiting();
    return mv[0] & mm2r[0] & !mhave;
  endfunction

  task automatic model_reset();
    mv = '0; mrw = '0; mm2r = '0; mpc = '0; malu = '0; mwr = '0;
    msz = '0; mun = 1'b0; mhave = 1'b0; mdata = '0; mret = '0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven
  task automatic model_edge();
    logic waiting;
    logic adv;
    waiting = model_waiting();
    adv     = !(if0.StallW | waiting);
    if (adv && !if0.FlushW) mret = mret + 32'($countones(mv));
    if (if0.FlushW) begin
      mv = '0;
    end else begin
      if (waiting && if0.dresp_data_ok) begin
        mhave = 1'b1;
        mdata = if0.dresp_data;
      end
      if (adv) begin
        mv = if0.ValidM; mpc = if0.PCM; malu = if0.ALUOutM; mwr = if0.WriteRegM;
        mrw = if0.RegWriteM; mm2r = if0.MemtoRegM; msz = if0.MemSizeM;
        mun = if0.MemUnsignedM;
        if (if0.ValidM[0] && if0.MemtoRegM[0]) begin
          mhave = if0.dresp_data_ok;
          if (if0.dresp_data_ok) mdata = if0.dresp_data;
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_result(input int i);
    int unsigned a;
    logic [31:0] v;
    if (i != 0 || !mm2r[0]) return malu[i];
    a = 32'(malu[0][1:0]);
    if (msz == 2'd0) begin
      v = (mdata >> (8 * a)) & 32'h0000_00ff;
      if (!mun && v >= 32'h80) v = v | 32'hffff_ff00;
    end else if (msz == 2'd1) begin
      v = (mdata >> ((a >= 2) ? 16 : 0)) & 32'h0000_ffff;
      if (!mun && v >= 32'h8000) v = v | 32'hffff_0000;
    end else begin
      v = mdata;
    end
    return v;
  endfunction

  function automatic logic [L-1:0] exp_we();
    logic [L-1:0] q;
    logic [L-1:0] r;
    for (int i = 0; i < L; i++) q[i] = mv[i] & mrw[i] & (mwr[i] != 5'd0);
    if (model_waiting()) q[0] = 1'b0;
    r = q;
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++)
        if (j > i && q[j] && mwr[j] == mwr[i]) r[i] = 1'b0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < L; i++) begin
      chk($sformatf("%s.pc%0d", tag, i), 64'(if0.PCW[i]), 64'(mpc[i]));
      chk($sformatf("%s.wr%0d", tag, i), 64'(if0.WriteRegW[i]), 64'(mwr[i]));
      chk($sformatf("%s.res%0d", tag, i), 64'(if0.ResultW[i]), 64'(exp_result(i)));
    end
    chk({tag, ".we"}, 64'(if0.RegWriteW), 64'(exp_we()));
    chk({tag, ".stall"}, 64'(if0.StallReqW), 64'(model_waiting()));
    chk({tag, ".ret"}, 64'(if0.RetiredW), 64'(mret));
    chk({tag, ".ret4"}, 64'(if1.RetiredW), 64'(mret[3:0]));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_idle();
    if0.StallW = 1'b0; if0.FlushW = 1'b0;
    if0.ValidM = '0; if0.PCM = '0; if0.ALUOutM = '0; if0.WriteRegM = '0;
    if0.RegWriteM = '0; if0.MemtoRegM = '0; if0.MemSizeM = 2'd2; if0.MemUnsignedM = 1'b0;
    if0.dresp_data_ok = 1'b0; if0.dresp_data = '0;
  endtask

  task automatic set_lane(input int i, input logic [31:0] pc, input logic [31:0] alu,
                          input logic [4:0] wr, input logic m2r);
    if0.ValidM[i] = 1'b1; if0.PCM[i] = pc; if0.ALUOutM[i] = alu;
    if0.WriteRegM[i] = wr; if0.RegWriteM[i] = 1'b1; if0.MemtoRegM[i] = m2r;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("reset");
  endtask

  logic [31:0] ret_snap;

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    set_idle();
    model_reset();
    #2;
    do_reset();
    chk("reset.ret_const", 64'(if0.RetiredW), 64'd0);

    // Two-lane ALU ops
    set_lane(0, 32'h100, 32'h11, 5'd3, 1'b0);
    set_lane(1, 32'h104, 32'h22, 5'd4, 1'b0);
    step("alu");
    chk("alu.we_const", 64'(if0.RegWriteW), 64'b11);
    chk("alu.res0_const", 64'(if0.ResultW[0]), 64'h11);
    chk("alu.res1_const", 64'(if0.ResultW[1]), 64'h22);
    set_idle();
    step("alu_out");
    chk("alu.ret_const", 64'(if0.RetiredW), 64'd2);

    // lb / lbu with response in the capture cycle
    for (int u = 0; u < 2; u++) begin
      set_idle();
      set_lane(0, 32'h200, 32'h0000_1003, 5'd8, 1'b1);
      if0.MemSizeM = 2'd0; if0.MemUnsignedM = u[0];
      if0.dresp_data_ok = 1'b1; if0.dresp_data = 32'h80AA_BBCC;
      step("lb");
      chk("lb.res_const", 64'(if0.ResultW[0]), (u == 0) ? 64'hFFFF_FF80 : 64'h0000_0080);
      chk("lb.we_const", 64'(if0.RegWriteW), 64'b01);
      set_idle();
      step("lb_out");
    end

    // lh at offset 2, response three cycles late
    set_idle();
    set_lane(0, 32'h300, 32'h0000_2002, 5'd9, 1'b1);
    if0.MemSizeM = 2'd1;
    step("lh_cap");
    set_idle();
    ret_snap = if0.RetiredW;
    for (int k = 0; k < 2; k++) begin
      chk("lh.stall_const", 64'(if0.StallReqW), 64'd1);
      chk("lh.hold_pc", 64'(if0.PCW[0]), 64'h300);
      step("lh_wait");
    end
    chk("lh.stall3_const", 64'(if0.StallReqW), 64'd1);
    chk("lh.we0_const", 64'(if0.RegWriteW[0]), 64'd0);
    if0.dresp_data_ok = 1'b1; if0.dresp_data = 32'h1234_8001;
    step("lh_resp");
    if0.dresp_data_ok = 1'b0;
    chk("lh.res_const", 64'(if0.ResultW[0]), 64'h0000_1234);
    chk("lh.we_ready", 64'(if0.RegWriteW[0]), 64'd1);
    chk("lh.stall_off", 64'(if0.StallReqW), 64'd0);
    step("lh_out");
    chk("lh.ret_plus1", 64'(if0.RetiredW), 64'(ret_snap + 32'd1));

    // WAW and r0
    set_idle();
    set_lane(0, 32'h400, 32'hA, 5'd5, 1'b0);
    set_lane(1, 32'h404, 32'hB, 5'd5, 1'b0);
    step("waw");
    chk("waw.we_const", 64'(if0.RegWriteW), 64'b10);
    set_idle();
    set_lane(0, 32'h408, 32'hC, 5'd0, 1'b0);
    step("r0");
    chk("r0.we_const", 64'(if0.RegWriteW), 64'b00);

    // Flush during wait, then a late response
    set_idle();
    set_lane(0, 32'h500, 32'h0000_3000, 5'd7, 1'b1);
    step("fl_cap");
    set_idle();
    if0.FlushW = 1'b1;
    step("fl_flush");
    ret_snap = if0.RetiredW;
    if0.FlushW = 1'b0;
    if0.dresp_data_ok = 1'b1; if0.dresp_data = 32'hDEAD_BEEF;
    step("fl_late");
    chk("fl.stall_const", 64'(if0.StallReqW), 64'd0);
    chk("fl.we_const", 64'(if0.RegWriteW), 64'b00);
    chk("fl.ret_same", 64'(if0.RetiredW), 64'(ret_snap));

    // Counter wrap on the 4-bit instance: 17 retirements
    set_idle();
    do_reset();
    for (int k = 0; k < 17; k++) begin
      set_idle();
      set_lane(0, 32'(k * 4), 32'(k), 5'd1, 1'b0);
      step("wrap");
    end
    set_idle();
    step("wrap_end");
    chk("wrap.ret4_const", 64'(if1.RetiredW), 64'd1);
    chk("wrap.ret32_const", 64'(if0.RetiredW), 64'd17);

    // Async reset mid-wait
    set_idle();
    set_lane(0, 32'h600, 32'h0000_4001, 5'd6, 1'b1);
    set_lane(1, 32'h604, 32'h55, 5'd2, 1'b0);
    step("rst_cap");
    set_idle();
    chk("rst.stall_pre", 64'(if0.StallReqW), 64'd1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst.stall_now", 64'(if0.StallReqW), 64'd0);
    chk("rst.we_now", 64'(if0.RegWriteW), 64'd0);
    chk("rst.pc_now", 64'(if0.PCW), 64'd0);
    chk("rst.res_now", 64'(if0.ResultW), 64'd0);
    chk("rst.ret_now", 64'(if0.RetiredW), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("rst_after");

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      set_idle();
      if0.StallW        = ($urandom_range(0, 99) < 15);
      if0.FlushW        = ($urandom_range(0, 99) < 5);
      if0.ValidM        = L'($urandom);
      if0.RegWriteM     = L'($urandom);
      if0.MemtoRegM[0]  = ($urandom_range(0, 99) < 40);
      if0.MemSizeM      = 2'($urandom_range(0, 2));
      if0.MemUnsignedM  = 1'($urandom);
      if0.dresp_data_ok = ($urandom_range(0, 99) < 35);
      if0.dresp_data    = $urandom;
      for (int i = 0; i < L; i++) begin
        if0.PCM[i]       = $urandom;
        if0.ALUOutM[i]   = $urandom;
        if0.WriteRegM[i] = 5'($urandom_range(0, 3));
      end
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
